zx_sram_arbiter: RTL

//  Time-shares the single 512K x8 external SRAM bus (va/vd/n_vrd/n_vwr) between three requesters:

---
 rtl/zx_sram_pkg.sv | 34 +++
 rtl/zx_sram_arbiter_prio_sel.sv | 52 +++++
 rtl/zx_sram_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/zx_sram_pkg.sv
// ---------------------------------------------------------------------------
// zx_sram_pkg
// Shared types and constants for the ZX external SRAM arbiter.
//   SRAM_AW      : SRAM address width (512K x8)
//   ROM_WP_TOP   : last address of the ROM image (first 16K)
//   AUX_WAIT_W   : width of the aux starvation counter
//   req_id_e     : requester identity
//   arb_state_e  : access sequencer state
//   is_rom_addr  : true for addresses inside the ROM image
// ---------------------------------------------------------------------------
package zx_sram_pkg;

  localparam int SRAM_AW    = 19;
  localparam int AUX_WAIT_W = 4;
  localparam logic [SRAM_AW-1:0] ROM_WP_TOP = 19'h03FFF;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_VID  = 2'd1,
    REQ_CPU  = 2'd2,
    REQ_AUX  = 2'd3
  } req_id_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_TURN   = 2'd2
  } arb_state_e;

  function automatic logic is_rom_addr(input logic [SRAM_AW-1:0] addr);
    return (addr <= ROM_WP_TOP);
  endfunction

endpackage

// File: rtl/zx_sram_arbiter_prio_sel.sv
// ---------------------------------------------------------------------------
// zx_sram_prio_sel
// Fixed-priority requester select with aux starvation relief.
// Order: vid > aux (once starved) > cpu > aux.
// Ports:
//   i_clk28, i_rst    : clock, synchronous active-high reset
//   i_vid_req/i_cpu_req/i_aux_req : live request lines
//   i_arb_en          : arbitration point; winner is committed on this cycle
//   o_winner          : combinational winner (REQ_NONE when nobody asks)
// ---------------------------------------------------------------------------
module zx_sram_prio_sel
  import zx_sram_pkg::*;
#(
  parameter int AUX_MAX_WAIT = 8
) (
  input  logic    i_clk28,
  input  logic    i_rst,
  input  logic    i_vid_req,
  input  logic    i_cpu_req,
  input  logic    i_aux_req,
  input  logic    i_arb_en,
  output req_id_e o_winner
);

  localparam logic [AUX_WAIT_W-1:0] L_MAX_WAIT = AUX_MAX_WAIT[AUX_WAIT_W-1:0];

  logic [AUX_WAIT_W-1:0] r_aux_wait;
  logic                  w_aux_starved;

  assign w_aux_starved = (r_aux_wait >= L_MAX_WAIT);

  always_comb begin
    o_winner = REQ_NONE;
    if (i_vid_req)                          o_winner = REQ_VID;
    else if (i_aux_req && w_aux_starved)    o_winner = REQ_AUX;
    else if (i_cpu_req)                     o_winner = REQ_CPU;
    else if (i_aux_req)                     o_winner = REQ_AUX;
  end

  // Counts CPU grants that aux lost; saturates at all-ones.
  always_ff @(posedge i_clk28) begin
    if (i_rst) begin
      r_aux_wait <= '0;
    end else if (i_arb_en) begin
      if (o_winner == REQ_AUX)
        r_aux_wait <= '0;
      else if (o_winner == REQ_CPU && i_aux_req && r_aux_wait != '1)
        r_aux_wait <= r_aux_wait + 1'b1;
    end
  end

endmodule

// File: rtl/zx_sram_arbiter.sv
// ---------------------------------------------------------------------------
// zx_sram_arbiter
// Time-shares the external 512K x8 SRAM between video fetch, Z80 CPU and an
// auxiliary DMA port, sequencing strobes at clk28 granularity.
// Optional feature macro: SRAM_ARB_ROM_WP_EN -- writes into the first 16K
// (ROM image) are acked but never strobed onto the SRAM.
// Ports:
//   i_clk28, i_rst                       : clock, synchronous active-high reset
//   i_vid_req/i_vid_addr                 : video read request (held until ack)
//   o_vid_ack/o_vid_rdata/o_vid_rvalid   : grant pulse, read data, data valid
//   i_cpu_req/we/addr/wdata, o_cpu_ack/rdata/rvalid : CPU port
//   i_aux_req/we/addr/wdata, o_aux_ack/rdata/rvalid : aux DMA port
//   o_va, i_vd_i, o_vd_o, o_vd_oe        : SRAM address / data bus
//   o_n_vrd, o_n_vwr                     : SRAM strobes, active low
//   o_busy                               : access or turnaround in progress
//
//   state     | meaning
//   ST_IDLE   | no access; arbitrate every cycle
//   ST_ACCESS | SRAM access, ACC_CYCLES long; arbitrate on last cycle
//   ST_TURN   | bus turnaround between a read and a following write
// ---------------------------------------------------------------------------
module zx_sram_arbiter
  import zx_sram_pkg::*;
#(
  parameter int ACC_CYCLES   = 2,
  parameter int TURNAROUND   = 1,
  parameter int AUX_MAX_WAIT = 8
) (
  input  logic               i_clk28,
  input  logic               i_rst,
  input  logic               i_vid_req,
  input  logic [SRAM_AW-1:0] i_vid_addr,
  output logic               o_vid_ack,
  output logic [7:0]         o_vid_rdata,
  output logic               o_vid_rvalid,
  input  logic               i_cpu_req,
  input  logic               i_cpu_we,
  input  logic [SRAM_AW-1:0] i_cpu_addr,
  input  logic [7:0]         i_cpu_wdata,
  output logic               o_cpu_ack,
  output logic [7:0]         o_cpu_rdata,
  output logic               o_cpu_rvalid,
  input  logic               i_aux_req,
  input  logic               i_aux_we,
  input  logic [SRAM_AW-1:0] i_aux_addr,
  input  logic [7:0]         i_aux_wdata,
  output logic               o_aux_ack,
  output logic [7:0]         o_aux_rdata,
  output logic               o_aux_rvalid,
  output logic [SRAM_AW-1:0] o_va,
  input  logic [7:0]         i_vd_i,
  output logic [7:0]         o_vd_o,
  output logic               o_vd_oe,
  output logic               o_n_vrd,
  output logic               o_n_vwr,
  output logic               o_busy
);

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] ACC_LOAD  = CNT_W'(ACC_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURNAROUND - 1);
  localparam bit HAS_TURN = (TURNAROUND > 0);

  arb_state_e         r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  req_id_e            r_owner, w_winner;
  logic               r_we, r_wp;
  logic [SRAM_AW-1:0] r_va;
  logic [7:0]         r_wdata;
  logic [7:0]         r_vid_rdata, r_cpu_rdata, r_aux_rdata;
  logic               r_vid_rvalid, r_cpu_rvalid, r_aux_rvalid;

  logic               w_last, w_first, w_arb_en, w_grant;
  logic               w_load_acc, w_load_turn;
  logic               w_win_we, w_win_wp, w_owner_req;
  logic [SRAM_AW-1:0] w_win_addr;
  logic [7:0]         w_win_wdata;
  logic               w_in_acc, w_acc_wr;

  assign w_in_acc = (r_state == ST_ACCESS);
  assign w_last   = (r_cnt == '0);
  assign w_first  = (r_cnt == ACC_LOAD);
  assign w_arb_en = (r_state == ST_IDLE) || (w_in_acc && w_last);
  assign w_grant  = w_arb_en && (w_winner != REQ_NONE);

  zx_sram_prio_sel #(
    .AUX_MAX_WAIT (AUX_MAX_WAIT)
  ) u_prio_sel (
    .i_clk28   (i_clk28),
    .i_rst     (i_rst),
    .i_vid_req (i_vid_req),
    .i_cpu_req (i_cpu_req),
    .i_aux_req (i_aux_req),
    .i_arb_en  (w_arb_en),
    .o_winner  (w_winner)
  );

  always_comb begin
    w_win_we    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    case (w_winner)
      REQ_VID: w_win_addr = i_vid_addr;
      REQ_CPU: begin
        w_win_we    = i_cpu_we;
        w_win_addr  = i_cpu_addr;
        w_win_wdata = i_cpu_wdata;
      end
      REQ_AUX: begin
        w_win_we    = i_aux_we;
        w_win_addr  = i_aux_addr;
        w_win_wdata = i_aux_wdata;
      end
      default: ;
    endcase
`ifdef SRAM_ARB_ROM_WP_EN
    w_win_wp = w_win_we && is_rom_addr(w_win_addr);
`else
    w_win_wp = 1'b0;
`endif
  end

  // A grant parked in TURN is dropped if its requester lets go meanwhile.
  always_comb begin
    w_owner_req = 1'b0;
    case (r_owner)
      REQ_VID: w_owner_req = i_vid_req;
      REQ_CPU: w_owner_req = i_cpu_req;
      REQ_AUX: w_owner_req = i_aux_req;
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge i_clk28) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next      = r_state;
    w_load_acc  = 1'b0;
    w_load_turn = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_next     = ST_ACCESS;
          w_load_acc = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (w_last) begin
          if (w_grant) begin
            if (HAS_TURN && !r_we && w_win_we) begin
              w_next      = ST_TURN;
              w_load_turn = 1'b1;
            end else begin
              w_next     = ST_ACCESS;
              w_load_acc = 1'b1;
            end
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      ST_TURN: begin
        if (w_last) begin
          if (w_owner_req) begin
            w_next     = ST_ACCESS;
            w_load_acc = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Cycle down-counter and latched access descriptor
  always_ff @(posedge i_clk28) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_owner <= REQ_NONE;
      r_we    <= 1'b0;
      r_wp    <= 1'b0;
      r_va    <= '0;
      r_wdata <= '0;
    end else begin
      if (w_load_acc)       r_cnt <= ACC_LOAD;
      else if (w_load_turn) r_cnt <= TURN_LOAD;
      else if (!w_last)     r_cnt <= r_cnt - 1'b1;
      if (w_grant) begin
        r_owner <= w_winner;
        r_we    <= w_win_we;
        r_wp    <= w_win_wp;
        r_va    <= w_win_addr;
        r_wdata <= w_win_wdata;
      end
    end
  end

  // Read data captured at the edge closing the last access cycle.
  always_ff @(posedge i_clk28) begin
    if (i_rst) begin
      r_vid_rdata  <= '0;
      r_cpu_rdata  <= '0;
      r_aux_rdata  <= '0;
      r_vid_rvalid <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_aux_rvalid <= 1'b0;
    end else begin
      r_vid_rvalid <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_aux_rvalid <= 1'b0;
      if (w_in_acc && w_last && !r_we) begin
        case (r_owner)
          REQ_VID: begin r_vid_rdata <= i_vd_i; r_vid_rvalid <= 1'b1; end
          REQ_CPU: begin r_cpu_rdata <= i_vd_i; r_cpu_rvalid <= 1'b1; end
          REQ_AUX: begin r_aux_rdata <= i_vd_i; r_aux_rvalid <= 1'b1; end
          default: ;
        endcase
      end
    end
  end

  // Outputs: strobes decode from registered state only, so no glitches.
  // Write enable waits one cycle after address/data settle.
  always_comb begin
    w_acc_wr     = w_in_acc && r_we && !r_wp;
    o_vid_ack    = w_in_acc && w_first && (r_owner == REQ_VID);
    o_cpu_ack    = w_in_acc && w_first && (r_owner == REQ_CPU);
    o_aux_ack    = w_in_acc && w_first && (r_owner == REQ_AUX);
    o_n_vrd      = !(w_in_acc && !r_we);
    o_vd_oe      = w_acc_wr;
    o_n_vwr      = !(w_acc_wr && !w_first);
    o_va         = r_va;
    o_vd_o       = r_wdata;
    o_busy       = (r_state != ST_IDLE);
    o_vid_rdata  = r_vid_rdata;
    o_cpu_rdata  = r_cpu_rdata;
    o_aux_rdata  = r_aux_rdata;
    o_vid_rvalid = r_vid_rvalid;
    o_cpu_rvalid = r_cpu_rvalid;
    o_aux_rvalid = r_aux_rvalid;
  end

endmodule
